// File: rtl/alu_mult_seq.sv
// alu_mult_seq: 32x32->64 shift-add multiplier that borrows the shared EX-stage ALU
module alu_mult_seq #(
  parameter logic [3:0] ADD_CMD = 4'b0000,
  parameter logic [3:0] SUB_CMD = 4'b0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_cmd,
  input  logic [31:0] alu_result
);
  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, NEG_LO, NEG_HI, NEG_INC, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] a, b, mcand, in1, in2, sum;
  logic [3:0] cmd;
  logic [4:0] cnt;
  logic sgn, neg, adv, take, c;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign alu_req = (state == ABS_A) ? sgn & a[31] :
                   (state == ABS_B) ? sgn & b[31] :
                   (state == ITER) ? lo[0] :
                   (state == NEG_LO || state == NEG_HI) ? neg :
                   (state == NEG_INC) ? neg & (lo == 32'd0) : 1'b0;
  assign adv = ~alu_req | alu_gnt;
  assign take = alu_req & alu_gnt;
  assign alu_in1 = alu_req ? in1 : 32'd0;
  assign alu_in2 = alu_req ? in2 : 32'd0;
  assign alu_cmd = alu_req ? cmd : ADD_CMD;
  assign sum = lo[0] ? alu_result : hi;
  assign c = lo[0] & (alu_result < hi);
  // operands and command each step would present to the ALU
  always_comb begin
    in1 = 32'd0;
    in2 = 32'd0;
    cmd = SUB_CMD;
    case (state)
      ABS_A: in2 = a;
      ABS_B: in2 = b;
      ITER: begin in1 = hi; in2 = mcand; cmd = ADD_CMD; end
      NEG_LO: in2 = lo;
      NEG_HI: begin in1 = 32'hFFFFFFFF; in2 = hi; end
      NEG_INC: begin in1 = hi; in2 = 32'd1; cmd = ADD_CMD; end
      default: cmd = ADD_CMD;
    endcase
  end
  // next state: ALU steps advance only once granted or when they need no ALU
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? ABS_A : IDLE;
      ABS_A: state_nx = adv ? ABS_B : ABS_A;
      ABS_B: state_nx = adv ? ITER : ABS_B;
      ITER: state_nx = (adv && cnt == 5'd31) ? NEG_LO : ITER;
      NEG_LO: state_nx = adv ? NEG_HI : NEG_LO;
      NEG_HI: state_nx = adv ? NEG_INC : NEG_HI;
      NEG_INC: state_nx = adv ? DONE : NEG_INC;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // datapath: capture, magnitude, shift-add iterations and final negation
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      mcand <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      neg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= op_a;
          b <= op_b;
          sgn <= is_signed;
          neg <= is_signed & (op_a[31] ^ op_b[31]);
          hi <= '0;
          cnt <= '0;
        end
        ABS_A: if (adv) mcand <= alu_req ? alu_result : a;
        ABS_B: if (adv) lo <= alu_req ? alu_result : b;
        ITER: if (adv) begin
          hi <= {c, sum[31:1]};
          lo <= {sum[0], lo[31:1]};
          cnt <= cnt + 5'd1;
        end
        NEG_LO: if (take) lo <= alu_result;
        NEG_HI, NEG_INC: if (take) hi <= alu_result;
        default: ;
      endcase
    end
  end
endmodule
